// File: rtl/buscaminas_ctrl.sv
// rtl/buscaminas_ctrl.sv - 8x8 minesweeper game controller with sequential neighbour scan
module buscaminas_ctrl #(
  parameter int N_MINES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] mine_map,
  input  logic        btn_down,
  input  logic        btn_right,
  input  logic        btn_reveal,
  input  logic        btn_flag,
  output logic [2:0]  fila,
  output logic [2:0]  col,
  output logic [63:0] revealed,
  output logic [63:0] flagged,
  output logic [6:0]  flags_left,
  input  logic [5:0]  disp_addr,
  output logic [3:0]  disp_count,
  output logic        playing,
  output logic        busy,
  output logic        won,
  output logic        lost
);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_COUNT, S_WRITE, S_WIN, S_LOSE
  } state_t;

  localparam logic [6:0] FLAGS_INIT = 7'(N_MINES);
  localparam logic [6:0] WIN_CNT    = 7'(64 - N_MINES);

  state_t      state;
  logic [63:0] mines;
  logic [3:0]  counts [64];
  logic [6:0]  revealed_cnt;
  logic [5:0]  target;
  logic [2:0]  k;
  logic [3:0]  acc;

  logic [5:0]  cur;
  logic [3:0]  dr, dc, nr, nc;
  logic        nb_hit;
  logic [3:0]  acc_next;
  logic [6:0]  cnt_next;

  assign cur      = {fila, col};
  assign cnt_next = revealed_cnt + 7'd1;

  assign playing = (state == S_PLAY) || (state == S_COUNT) || (state == S_WRITE);
  assign busy    = (state == S_COUNT) || (state == S_WRITE);
  assign won     = (state == S_WIN);
  assign lost    = (state == S_LOSE);

  // Offsets encoded as 4-bit two's complement; bit 3 of the sum flags off-board (-1 or 8).
  always_comb begin
    dr = 4'h0;
    dc = 4'h0;
    case (k)
      3'd0: begin dr = 4'hF; dc = 4'hF; end
      3'd1: begin dr = 4'hF; dc = 4'h0; end
      3'd2: begin dr = 4'hF; dc = 4'h1; end
      3'd3: begin dr = 4'h0; dc = 4'hF; end
      3'd4: begin dr = 4'h0; dc = 4'h1; end
      3'd5: begin dr = 4'h1; dc = 4'hF; end
      3'd6: begin dr = 4'h1; dc = 4'h0; end
      default: begin dr = 4'h1; dc = 4'h1; end
    endcase
    nr       = {1'b0, target[5:3]} + dr;
    nc       = {1'b0, target[2:0]} + dc;
    nb_hit   = !nr[3] && !nc[3] && mines[{nr[2:0], nc[2:0]}];
    acc_next = acc + {3'b000, nb_hit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mines        <= '0;
      revealed     <= '0;
      flagged      <= '0;
      fila         <= '0;
      col          <= '0;
      flags_left   <= FLAGS_INIT;
      revealed_cnt <= '0;
      target       <= '0;
      k            <= '0;
      acc          <= '0;
      disp_count   <= '0;
      for (int i = 0; i < 64; i++) counts[i] <= '0;
    end else begin
      disp_count <= counts[disp_addr];
      if (start) begin
        state        <= S_PLAY;
        mines        <= mine_map;
        revealed     <= '0;
        flagged      <= '0;
        fila         <= '0;
        col          <= '0;
        flags_left   <= FLAGS_INIT;
        revealed_cnt <= '0;
        k            <= '0;
        acc          <= '0;
        for (int i = 0; i < 64; i++) counts[i] <= '0;
      end else begin
        case (state)
          S_PLAY: begin
            if (btn_down)  fila <= fila + 3'd1;
            if (btn_right) col  <= col + 3'd1;
            // Reveal takes priority; a simultaneous flag pulse is discarded.
            if (btn_reveal) begin
              if (!revealed[cur] && !flagged[cur]) begin
                target <= cur;
                k      <= '0;
                acc    <= '0;
                state  <= mines[cur] ? S_LOSE : S_COUNT;
              end
            end else if (btn_flag && !revealed[cur]) begin
              if (flagged[cur]) begin
                flagged[cur] <= 1'b0;
                flags_left   <= flags_left + 7'd1;
              end else if (flags_left != 7'd0) begin
                flagged[cur] <= 1'b1;
                flags_left   <= flags_left - 7'd1;
              end
            end
          end
          S_COUNT: begin
            acc <= acc_next;
            k   <= k + 3'd1;
            if (k == 3'd7) state <= S_WRITE;
          end
          S_WRITE: begin
            counts[target]   <= acc;
            revealed[target] <= 1'b1;
            revealed_cnt     <= cnt_next;
            state            <= (cnt_next == WIN_CNT) ? S_WIN : S_PLAY;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buscaminas_ctrl.sv
// tb/tb_buscaminas_ctrl.sv - directed self-checking bench for buscaminas_ctrl
module tb_buscaminas_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] mine_map = '0;
  logic        btn_down = 1'b0, btn_right = 1'b0, btn_reveal = 1'b0, btn_flag = 1'b0;
  logic [2:0]  fila, col;
  logic [63:0] revealed, flagged;
  logic [6:0]  flags_left;
  logic [5:0]  disp_addr = '0;
  logic [3:0]  disp_count;
  logic        playing, busy, won, lost;

  int checks = 0;
  int errors = 0;
  logic [2:0] cur_r = 3'd0, cur_c = 3'd0;

  buscaminas_ctrl #(.N_MINES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mine_map(mine_map),
    .btn_down(btn_down), .btn_right(btn_right), .btn_reveal(btn_reveal), .btn_flag(btn_flag),
    .fila(fila), .col(col), .revealed(revealed), .flagged(flagged), .flags_left(flags_left),
    .disp_addr(disp_addr), .disp_count(disp_count),
    .playing(playing), .busy(busy), .won(won), .lost(lost)
  );

  always #5 clk = ~clk;

  task automatic pulse(input logic d, input logic r, input logic rv, input logic f);
    @(negedge clk);
    btn_down = d; btn_right = r; btn_reveal = rv; btn_flag = f;
    @(negedge clk);
    btn_down = 1'b0; btn_right = 1'b0; btn_reveal = 1'b0; btn_flag = 1'b0;
  endtask

  task automatic do_start(input logic [63:0] m);
    @(negedge clk);
    start = 1'b1; mine_map = m;
    @(negedge clk);
    start = 1'b0;
    cur_r = 3'd0; cur_c = 3'd0;
  endtask

  task automatic goto(input logic [2:0] r, input logic [2:0] c);
    while (cur_r != r) begin pulse(1'b1, 1'b0, 1'b0, 1'b0); cur_r = cur_r + 3'd1; end
    while (cur_c != c) begin pulse(1'b0, 1'b1, 1'b0, 1'b0); cur_c = cur_c + 3'd1; end
  endtask

  task automatic reveal_at(input logic [2:0] r, input logic [2:0] c, output int n);
    goto(r, c);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
  endtask

  task automatic read_count(input logic [5:0] a, output logic [3:0] v);
    disp_addr = a;
    @(negedge clk);
    v = disp_count;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (fila !== 3'd0 || col !== 3'd0) begin errors++; $display("FAIL reset_cursor got %0d,%0d exp 0,0", fila, col); end
    checks++; if (revealed !== 64'd0 || flagged !== 64'd0) begin errors++; $display("FAIL reset_maps got %h %h exp 0 0", revealed, flagged); end
    checks++; if (flags_left !== 7'd10) begin errors++; $display("FAIL reset_flags_left got %0d exp 10", flags_left); end
    checks++; if ({playing, busy, won, lost} !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp 0000", {playing, busy, won, lost}); end
    checks++; if (disp_count !== 4'd0) begin errors++; $display("FAIL reset_disp got %0d exp 0", disp_count); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (fila !== 3'd0 || col !== 3'd0) begin errors++; $display("FAIL idle_ignore got %0d,%0d exp 0,0", fila, col); end
  endtask

  task automatic test_start;
    do_start(64'd0);
    checks++; if (playing !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL start_play got %b%b exp 10", playing, busy); end
    checks++; if (fila !== 3'd0 || col !== 3'd0 || revealed !== 64'd0 || flags_left !== 7'd10) begin
      errors++; $display("FAIL start_state got %0d,%0d %h %0d exp 0,0 0 10", fila, col, revealed, flags_left); end
  endtask

  task automatic test_cursor;
    logic [2:0] e;
    for (int i = 1; i <= 8; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      e = 3'(i);
      checks++; if (fila !== e) begin errors++; $display("FAIL cursor_down%0d got %0d exp %0d", i, fila, e); end
    end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (fila !== 3'd1 || col !== 3'd1) begin errors++; $display("FAIL cursor_diag got %0d,%0d exp 1,1", fila, col); end
    cur_r = 3'd1; cur_c = 3'd1;
  endtask

  task automatic test_reveal_count;
    int n; logic [3:0] v;
    do_start(64'h302);
    reveal_at(3'd0, 3'd0, n);
    checks++; if (n != 9) begin errors++; $display("FAIL busy_cycles got %0d exp 9", n); end
    checks++; if (revealed !== 64'h1 || playing !== 1'b1) begin errors++; $display("FAIL reveal_bit got %h %b exp 1 1", revealed, playing); end
    read_count(6'd0, v);
    checks++; if (v !== 4'd3) begin errors++; $display("FAIL count_00 got %0d exp 3", v); end
  endtask

  task automatic test_clip;
    int n; logic [3:0] v;
    do_start(64'h80);
    reveal_at(3'd7, 3'd7, n);
    read_count(6'd63, v);
    checks++; if (v !== 4'd0 || revealed[63] !== 1'b1) begin errors++; $display("FAIL clip_77 got %0d %b exp 0 1", v, revealed[63]); end
    reveal_at(3'd0, 3'd6, n);
    read_count(6'd6, v);
    checks++; if (v !== 4'd1) begin errors++; $display("FAIL clip_06 got %0d exp 1", v); end
    reveal_at(3'd0, 3'd0, n);
    read_count(6'd0, v);
    checks++; if (v !== 4'd0 || revealed !== 64'h8000_0000_0000_0041) begin errors++; $display("FAIL clip_00 got %0d %h exp 0 8000000000000041", v, revealed); end
  endtask

  task automatic test_flags;
    int n;
    do_start(64'd0);
    for (int i = 0; i < 10; i++) begin
      goto(3'(i / 8), 3'(i % 8));
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++; if (flags_left !== 7'd0 || flagged !== 64'h3FF) begin errors++; $display("FAIL flag10 got %0d %h exp 0 3ff", flags_left, flagged); end
    goto(3'd2, 3'd0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (flags_left !== 7'd0 || flagged !== 64'h3FF) begin errors++; $display("FAIL flag11 got %0d %h exp 0 3ff", flags_left, flagged); end
    goto(3'd0, 3'd0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (flags_left !== 7'd1 || flagged !== 64'h3FE) begin errors++; $display("FAIL unflag got %0d %h exp 1 3fe", flags_left, flagged); end
    goto(3'd0, 3'd1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (busy !== 1'b0 || revealed !== 64'd0 || playing !== 1'b1) begin errors++; $display("FAIL reveal_flagged got %b %h exp 0 0", busy, revealed); end
    goto(3'd2, 3'd0);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reveal_over_flag got busy %b exp 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    checks++; if (flagged !== 64'h3FE || flags_left !== 7'd1 || revealed !== 64'h1_0000) begin
      errors++; $display("FAIL flag_dropped got %h %0d %h exp 3fe 1 10000", flagged, flags_left, revealed); end
  endtask

  task automatic test_loss;
    do_start(64'h1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (lost !== 1'b1 || playing !== 1'b0 || revealed !== 64'd0) begin errors++; $display("FAIL loss got %b %b %h exp 1 0 0", lost, playing, revealed); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fila !== 3'd0 || lost !== 1'b1) begin errors++; $display("FAIL lose_hold got %0d %b exp 0 1", fila, lost); end
  endtask

  task automatic test_abort;
    do_start(64'd0);
    goto(3'd3, 3'd3);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    do_start(64'd0);
    checks++; if (playing !== 1'b1 || busy !== 1'b0 || fila !== 3'd0 || col !== 3'd0 || flags_left !== 7'd10) begin
      errors++; $display("FAIL abort_state got %b%b %0d,%0d %0d exp 10 0,0 10", playing, busy, fila, col, flags_left); end
    repeat (12) @(negedge clk);
    checks++; if (revealed !== 64'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_write got %h %b exp 0 0", revealed, busy); end
  endtask

  task automatic test_win;
    int n; int bad; logic [3:0] v;
    bad = 0;
    do_start(64'hFFC0_0000_0000_0000);
    for (int i = 0; i < 54; i++) begin
      reveal_at(3'(i / 8), 3'(i % 8), n);
      if (n != 9) bad++;
      if (i < 53 && playing !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL win_sweep got %0d bad reveals exp 0", bad); end
    checks++; if (won !== 1'b1 || playing !== 1'b0 || revealed !== 64'h003F_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL win got %b %b %h exp 1 0 003fffffffffffff", won, playing, revealed); end
    read_count(6'd53, v);
    checks++; if (v !== 4'd4) begin errors++; $display("FAIL count_53 got %0d exp 4", v); end
    read_count(6'd46, v);
    checks++; if (v !== 4'd2) begin errors++; $display("FAIL count_46 got %0d exp 2", v); end
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (fila !== cur_r || flagged !== 64'd0 || won !== 1'b1) begin errors++; $display("FAIL win_hold got %0d %h %b exp %0d 0 1", fila, flagged, won, cur_r); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_cursor();
    test_reveal_count();
    test_clip();
    test_flags();
    test_loss();
    test_abort();
    test_win();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buscaminas_ctrl.md
# buscaminas_ctrl

Game controller for the 8x8 minesweeper board. Consumes debounced single-cycle button pulses, owns the cursor, the revealed/flagged bitmaps and the per-cell neighbour-count memory, and sequences each reveal through a multi-cycle neighbour scan. It detects win and loss and exposes a registered read port for the display driver.

## Interface
- N_MINES, 10: mines on the board (1..63); sets the initial flag budget and the win threshold of 64-N_MINES revealed cells.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; latch mine_map and begin a new game
- mine_map  in  64  mine bitmap, bit index = fila*8+col; sampled only on start
- btn_down  in  1  pulse; cursor row +1
- btn_right  in  1  pulse; cursor column +1
- btn_reveal  in  1  pulse; reveal cell under cursor
- btn_flag  in  1  pulse; toggle flag under cursor
- fila  out  3  cursor row
- col  out  3  cursor column
- revealed  out  64  revealed bitmap
- flagged  out  64  flagged bitmap
- flags_left  out  7  N_MINES minus flags placed
- disp_addr  in  6  display read address (fila*8+col)
- disp_count  out  4  neighbour count of cell disp_addr, registered, 1-cycle latency
- playing  out  1  state is PLAY, COUNT or WRITE
- busy  out  1  state is COUNT or WRITE
- won  out  1  state is WIN
- lost  out  1  state is LOSE

## Operation
- States: IDLE, PLAY, COUNT, WRITE, WIN, LOSE. Reset -> IDLE.
- start, in any state: next cycle -> PLAY. Latch mine_map. Clear revealed, flagged and all counts. Cursor to (0,0). flags_left = N_MINES. Aborts an in-progress COUNT/WRITE.
- Inputs other than start are ignored in IDLE, WIN and LOSE.
- PLAY, btn_down: fila = fila+1, wrapping 7->0.
- PLAY, btn_right: col = col+1, wrapping 7->0.
- Down and right in the same cycle both apply.
- PLAY, btn_reveal on a cell that is neither revealed nor flagged:
  - Target address is latched from the pre-move cursor.
  - Mine at target -> LOSE.
  - No mine -> COUNT.
  - Revealed or flagged target: no action.
- PLAY, btn_flag on an unrevealed cell:
  - Flagged cell: clear the flag, flags_left+1.
  - Unflagged cell with flags_left>0: set the flag, flags_left-1.
  - Unflagged cell with flags_left=0: no action.
  - Revealed cell: no action.
- Reveal and flag pulsed together: reveal wins, flag dropped. Cursor moves in the same cycle still apply.
- COUNT: 3-bit index k steps through the 8 neighbours, one per cycle, order (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1).
  - Out-of-board neighbours contribute 0; no wrap.
  - Accumulator is 4 bits, range 0..8.
- WRITE: store count at target, set revealed[target], revealed_cnt+1 (7-bit).
  - New revealed_cnt == 64-N_MINES -> WIN, else -> PLAY.
- All button pulses in COUNT/WRITE are dropped; no queuing.
- LOSE/WIN hold revealed, flagged, cursor and counts until start or reset.
- No flood-fill; a zero count reveals one cell only.

## Timing
- Reset values: fila=0, col=0, revealed=0, flagged=0, flags_left=N_MINES, disp_count=0, playing=busy=won=lost=0, all counts 0, revealed_cnt=0.
- Cursor and flag updates visible 1 cycle after the pulse edge.
- Reveal sampled at edge t:
  - COUNT on cycles t+1..t+8.
  - WRITE on t+9.
  - revealed bit, count and PLAY/WIN visible at t+10.
- Mine hit: lost=1 and playing=0 at t+1; revealed unchanged.
- disp_count reflects the count of disp_addr sampled one edge earlier. A count written in WRITE is readable on the following cycle.
- start latency: PLAY and cleared state visible 1 cycle after the pulse.

## Test plan
- Reset then start with mine_map=0: fila=col=0, flags_left=10, playing=1, revealed=0.
- 8 btn_down pulses: fila 1..7 then 0. btn_down+btn_right in the same cycle from (0,0): cursor (1,1).
- Mines at bits 1,8,9. Reveal (0,0):
  - busy=1 for exactly 9 cycles.
  - revealed[0]=1 at t+10.
  - disp_addr=0 returns 3.
- Corner/edge clip: single mine at bit 7. Reveal (7,7): count 0. Reveal (0,6): count 1, no wrap contribution.
- Flag budget with N_MINES=10:
  - Flag 10 cells: flags_left=0.
  - 11th flag ignored.
  - Unflag one: flags_left=1.
  - Reveal on a flagged cell: no state change.
- Loss and win:
  - Reveal a mine: lost=1 next cycle.
  - start mid-COUNT: aborts to PLAY with cleared state.
  - Reveal all 54 safe cells: won=1 at t+10 of the last reveal; further buttons ignored.
